mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-bus access controller: IDLE/ADDR/DATA/HOLD handshake FSM with flush discard.
// Optional ADDR_MAP_SEG_EN maps kseg0/kseg1 addresses to physical by clearing bits [31:29].
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mem_ren,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        addr_err,
    input  logic        flush,
    input  logic        pipe_stall,
    output logic        mem_stall,
    output logic [31:0] mem_rdata,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10,
        HOLD = 2'b11
    } state_t;

    state_t      state;
    logic        discard;
    logic [3:0]  en;
    logic [2:0]  en_count;
    logic [1:0]  size;
    logic [31:0] addr_mapped;
    logic        access_valid;

    // A combined read/write enable is a write, so its write mask sets the size.
    assign en       = (mem_wen != 4'b0000) ? mem_wen : mem_ren;
    assign en_count = 3'(en[0]) + 3'(en[1]) + 3'(en[2]) + 3'(en[3]);

    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        size = 2'b10;
        case (en_count)
            3'd1:    size = 2'b00;
            3'd2:    size = 2'b01;
            default: size = 2'b10;
        endcase
    end

`ifdef ADDR_MAP_SEG_EN
    always_comb begin
        addr_mapped = mem_addr;
        if (mem_addr[31:30] == 2'b10) begin
            addr_mapped[31:29] = 3'b000;
        end
    end
`else
    assign addr_mapped = mem_addr;
`endif

    assign access_valid = (state == IDLE) && ((mem_ren | mem_wen) != 4'b0000)
                          && !addr_err && !flush;

    // The IDLE term must be combinational so the stage stalls in the access cycle itself.
    assign mem_stall = access_valid || (state == ADDR) || (state == DATA);

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            discard    <= 1'b0;
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= 2'b00;
            data_addr  <= 32'h0;
            data_wdata <= 32'h0;
            mem_rdata  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    discard <= 1'b0;
                    if (access_valid) begin
                        state      <= ADDR;
                        data_req   <= 1'b1;
                        data_wr    <= |mem_wen;
                        data_size  <= size;
                        data_addr  <= addr_mapped;
                        data_wdata <= mem_wdata;
                    end
                end
                ADDR: begin
                    // The bus cannot complete in the acceptance cycle, so data_data_ok is ignored here.
                    if (flush) begin
                        discard <= 1'b1;
                    end
                    if (data_addr_ok) begin
                        state    <= DATA;
                        data_req <= 1'b0;
                    end
                end
                DATA: begin
                    if (data_data_ok) begin
                        if (discard || flush) begin
                            state   <= IDLE;
                            discard <= 1'b0;
                        end else begin
                            state <= HOLD;
                            if (!data_wr) begin
                                mem_rdata <= data_rdata;
                            end
                        end
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end
                HOLD: begin
                    if (flush || !pipe_stall) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: bus requests are scored against a queue of
// expected transactions, load data against a queue of expected read words.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  mem_ren;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        addr_err;
    logic        flush;
    logic        pipe_stall;
    logic        mem_stall;
    logic [31:0] mem_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t        exp_q[$];
    logic [31:0] rd_q[$];
    req_t        mon_e;
    logic [31:0] exp_rdata;
    int          errors;
    int          checks;

    mem_access_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .mem_ren      (mem_ren),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .addr_err     (addr_err),
        .flush        (flush),
        .pipe_stall   (pipe_stall),
        .mem_stall    (mem_stall),
        .mem_rdata    (mem_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every accepted bus request must match the oldest expected transaction.
    always @(negedge clk) begin
        if (!rst && data_req && data_addr_ok) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bus_req_unexpected got wr=%b size=%b addr=%h wdata=%h, none expected",
                         data_wr, data_size, data_addr, data_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({data_wr, data_size, data_addr, data_wdata} !== mon_e) begin
                    errors++;
                    $display("FAIL bus_req got wr=%b size=%b addr=%h wdata=%h exp wr=%b size=%b addr=%h wdata=%h",
                             data_wr, data_size, data_addr, data_wdata,
                             mon_e.wr, mon_e.size, mon_e.addr, mon_e.wdata);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        mem_ren      = 4'b0000;
        mem_wen      = 4'b0000;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        addr_err     = 1'b0;
        flush        = 1'b0;
        pipe_stall   = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
    endtask

    // Drive an access from the decoder and record the bus request it must produce.
    task automatic issue(input logic [3:0] ren, input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic e_wr, input logic [1:0] e_size,
                         input logic [31:0] e_addr);
        mem_ren   = ren;
        mem_wen   = wen;
        mem_addr  = addr;
        mem_wdata = wdata;
        exp_q.push_back({e_wr, e_size, e_addr, wdata});
    endtask

    // Minimum-latency bus response; returns in the first cycle after data_data_ok.
    task automatic run_min(input logic [31:0] rdata);
        tick(); data_addr_ok = 1'b1;
        tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = rdata;
        tick(); data_data_ok = 1'b0; data_rdata = 32'h0;
    endtask

    task automatic test_reset();
        clear_in();
        rst = 1'b1;
        tick(); data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
        tick(); tick();
        rst = 1'b0; clear_in(); #1;
        checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL reset_data_req got=%b exp=0", data_req); end
        checks++; if (data_wr !== 1'b0) begin errors++; $display("FAIL reset_data_wr got=%b exp=0", data_wr); end
        checks++; if (data_size !== 2'b00) begin errors++; $display("FAIL reset_data_size got=%b exp=00", data_size); end
        checks++; if (data_addr !== 32'h0) begin errors++; $display("FAIL reset_data_addr got=%h exp=0", data_addr); end
        checks++; if (data_wdata !== 32'h0) begin errors++; $display("FAIL reset_data_wdata got=%h exp=0", data_wdata); end
        checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_mem_rdata got=%h exp=0", mem_rdata); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_mem_stall got=%b exp=0", mem_stall); end
        exp_rdata = 32'h0;
    endtask

    task automatic test_lw();
        tick(); clear_in();
        issue(4'b1111, 4'b0000, 32'h0000_0010, 32'h0, 1'b0, 2'b10, 32'h0000_0010); #1;
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL lw_stall_n got=%b exp=1", mem_stall); end
        tick(); data_addr_ok = 1'b1; #1;
        checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL lw_req_n1 got=%b exp=1", data_req); end
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL lw_stall_n1 got=%b exp=1", mem_stall); end
        tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        rd_q.push_back(32'hDEAD_BEEF); #1;
        checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL lw_req_n2 got=%b exp=0", data_req); end
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL lw_stall_n2 got=%b exp=1", mem_stall); end
        tick(); data_data_ok = 1'b0; data_rdata = 32'h0; #1;
        exp_rdata = rd_q.pop_front();
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL lw_stall_n3 got=%b exp=0", mem_stall); end
        checks++; if (mem_rdata !== exp_rdata) begin errors++; $display("FAIL lw_rdata got=%h exp=%h", mem_rdata, exp_rdata); end
        tick(); clear_in(); #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL lw_idle_stall got=%b exp=0", mem_stall); end
    endtask

    task automatic test_sb_delayed();
        tick(); clear_in();
        issue(4'b0000, 4'b0100, 32'h0000_0022, 32'h5A5A_5A5A, 1'b1, 2'b00, 32'h0000_0022);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) data_addr_ok = 1'b1;
            #1;
            checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL sb_req_hold%0d got=%b exp=1", i, data_req); end
            checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL sb_stall_hold%0d got=%b exp=1", i, mem_stall); end
        end
        tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF; #1;
        checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL sb_req_drop got=%b exp=0", data_req); end
        tick(); data_data_ok = 1'b0; data_rdata = 32'h0; #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL sb_hold_stall got=%b exp=0", mem_stall); end
        checks++; if (mem_rdata !== exp_rdata) begin errors++; $display("FAIL sb_rdata_kept got=%h exp=%h", mem_rdata, exp_rdata); end
        tick(); clear_in();
    endtask

    task automatic test_addr_err();
        tick(); clear_in();
        mem_ren = 4'b1111; mem_addr = 32'h0000_0013; addr_err = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL aerr_stall%0d got=%b exp=0", i, mem_stall); end
            checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL aerr_req%0d got=%b exp=0", i, data_req); end
            tick();
        end
        clear_in();
    endtask

    task automatic test_flush_discard();
        tick(); clear_in();
        issue(4'b1111, 4'b0000, 32'h0000_0040, 32'h0, 1'b0, 2'b10, 32'h0000_0040);
        tick(); data_addr_ok = 1'b1;
        tick(); data_addr_ok = 1'b0; flush = 1'b1; #1;
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL fl_stall_data got=%b exp=1", mem_stall); end
        tick(); flush = 1'b0; mem_ren = 4'b0000; #1;
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL fl_stall_discard got=%b exp=1", mem_stall); end
        data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
        tick(); data_data_ok = 1'b0; data_rdata = 32'h0;
        issue(4'b1111, 4'b0000, 32'h0000_0044, 32'h0, 1'b0, 2'b10, 32'h0000_0044); #1;
        checks++; if (mem_rdata !== exp_rdata) begin errors++; $display("FAIL fl_rdata_kept got=%h exp=%h", mem_rdata, exp_rdata); end
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL fl_back_idle got=%b exp=1", mem_stall); end
        rd_q.push_back(32'h0F0F_0F0F);
        run_min(32'h0F0F_0F0F); #1;
        exp_rdata = rd_q.pop_front();
        checks++; if (mem_rdata !== exp_rdata) begin errors++; $display("FAIL fl_next_rdata got=%h exp=%h", mem_rdata, exp_rdata); end
        tick(); clear_in();
    endtask

    task automatic test_hold();
        tick(); clear_in();
        issue(4'b1111, 4'b0000, 32'h0000_0080, 32'h0, 1'b0, 2'b10, 32'h0000_0080);
        tick(); data_addr_ok = 1'b1;
        tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D; pipe_stall = 1'b1;
        rd_q.push_back(32'hCAFE_F00D);
        tick(); data_data_ok = 1'b0; data_rdata = 32'h0; #1;
        exp_rdata = rd_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) data_rdata = 32'h1111_1111;
            if (i == 2) pipe_stall = 1'b0;
            #1;
            checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL hold_stall%0d got=%b exp=0", i, mem_stall); end
            checks++; if (mem_rdata !== exp_rdata) begin errors++; $display("FAIL hold_rdata%0d got=%h exp=%h", i, mem_rdata, exp_rdata); end
            checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL hold_req%0d got=%b exp=0", i, data_req); end
            tick();
        end
        clear_in(); #1;
        checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL hold_exit_req got=%b exp=0", data_req); end
    endtask

    task automatic test_flush_idle_hold();
        tick(); clear_in();
        mem_ren = 4'b1111; mem_addr = 32'h0000_0400; flush = 1'b1; #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL fidle_stall got=%b exp=0", mem_stall); end
        tick(); clear_in(); #1;
        checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL fidle_req got=%b exp=0", data_req); end
        issue(4'b1111, 4'b0000, 32'h0000_0500, 32'h0, 1'b0, 2'b10, 32'h0000_0500);
        tick(); data_addr_ok = 1'b1;
        tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D; pipe_stall = 1'b1;
        rd_q.push_back(32'h0BAD_F00D);
        tick(); data_data_ok = 1'b0; data_rdata = 32'h0; flush = 1'b1; #1;
        exp_rdata = rd_q.pop_front();
        checks++; if (mem_rdata !== exp_rdata) begin errors++; $display("FAIL fhold_rdata got=%h exp=%h", mem_rdata, exp_rdata); end
        tick(); flush = 1'b0;
        issue(4'b0011, 4'b0000, 32'h0000_0600, 32'h0, 1'b0, 2'b01, 32'h0000_0600); #1;
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL fhold_to_idle got=%b exp=1", mem_stall); end
        pipe_stall = 1'b0;
        rd_q.push_back(32'h0000_7777);
        run_min(32'h0000_7777); #1;
        exp_rdata = rd_q.pop_front();
        checks++; if (mem_rdata !== exp_rdata) begin errors++; $display("FAIL fhold_next_rdata got=%h exp=%h", mem_rdata, exp_rdata); end
        tick(); clear_in();
    endtask

    task automatic test_back_to_back();
        tick(); clear_in();
        issue(4'b0000, 4'b0011, 32'h0000_0102, 32'hBEEF_BEEF, 1'b1, 2'b01, 32'h0000_0102);
        run_min(32'hFFFF_FFFF); #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL b2b_sh_hold got=%b exp=0", mem_stall); end
        checks++; if (mem_rdata !== exp_rdata) begin errors++; $display("FAIL b2b_sh_rdata got=%h exp=%h", mem_rdata, exp_rdata); end
        tick();
        issue(4'b0001, 4'b0011, 32'h0000_0104, 32'h1234_1234, 1'b1, 2'b01, 32'h0000_0104); #1;
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL b2b_rw_stall got=%b exp=1", mem_stall); end
        run_min(32'h0); #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL b2b_rw_hold got=%b exp=0", mem_stall); end
        tick();
        issue(4'b0100, 4'b0000, 32'h0000_0202, 32'h0, 1'b0, 2'b00, 32'h0000_0202); #1;
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL b2b_lb_stall got=%b exp=1", mem_stall); end
        rd_q.push_back(32'h00AB_0000);
        run_min(32'h00AB_0000); #1;
        exp_rdata = rd_q.pop_front();
        checks++; if (mem_rdata !== exp_rdata) begin errors++; $display("FAIL b2b_lb_rdata got=%h exp=%h", mem_rdata, exp_rdata); end
        tick(); clear_in();
    endtask

    task automatic test_seg_map();
        logic [31:0] e_k1;
        logic [31:0] e_k0;
`ifdef ADDR_MAP_SEG_EN
        e_k1 = 32'h1FC0_0004;
        e_k0 = 32'h0000_1000;
`else
        e_k1 = 32'hBFC0_0004;
        e_k0 = 32'h8000_1000;
`endif
        tick(); clear_in();
        issue(4'b1111, 4'b0000, 32'hBFC0_0004, 32'h0, 1'b0, 2'b10, e_k1);
        run_min(32'h0000_0001);
        tick();
        issue(4'b1111, 4'b0000, 32'h8000_1000, 32'h0, 1'b0, 2'b10, e_k0);
        run_min(32'h0000_0002);
        tick();
        issue(4'b0000, 4'b1111, 32'hC000_0004, 32'hA5A5_A5A5, 1'b1, 2'b10, 32'hC000_0004);
        run_min(32'h0);
        tick(); clear_in();
        exp_rdata = 32'h0000_0002;
        #1;
        checks++; if (mem_rdata !== exp_rdata) begin errors++; $display("FAIL seg_rdata got=%h exp=%h", mem_rdata, exp_rdata); end
    endtask

    task automatic test_reset_mid();
        tick(); clear_in();
        issue(4'b1111, 4'b0000, 32'h0000_0300, 32'h0, 1'b0, 2'b10, 32'h0000_0300);
        tick(); data_addr_ok = 1'b1;
        tick(); data_addr_ok = 1'b0; rst = 1'b1;
        tick(); rst = 1'b0; clear_in(); data_data_ok = 1'b1; data_rdata = 32'h5555_5555; #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rmid_stall got=%b exp=0", mem_stall); end
        checks++; if (data_addr !== 32'h0) begin errors++; $display("FAIL rmid_addr got=%h exp=0", data_addr); end
        tick(); data_data_ok = 1'b0; data_rdata = 32'h0; #1;
        checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rmid_rdata got=%h exp=0", mem_rdata); end
        checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL rmid_req got=%b exp=0", data_req); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rmid_idle_stall got=%b exp=0", mem_stall); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        clear_in();
        test_reset();
        test_lw();
        test_sb_delayed();
        test_addr_err();
        test_flush_discard();
        test_hold();
        test_flush_idle_hold();
        test_back_to_back();
        test_seg_map();
        test_reset_mid();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
